// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the lab CPU fetch/decode/execute sequencer.
// Holds the state encoding, instruction field positions and the retire-counter helper.
package cpu_seq_pkg;

    localparam int unsigned PC_W_DEF = 8;
    localparam int unsigned INSTR_W  = 9;
    localparam int unsigned OFFS_MSB = 4;
    localparam int unsigned OFFS_LSB = 0;
    localparam int unsigned OFFS_W   = OFFS_MSB - OFFS_LSB + 1;
    localparam int unsigned RETIRE_W = 16;
    localparam int unsigned TMO_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } seq_state_t;

    // Retired-instruction count sticks at all-ones instead of wrapping.
    function automatic logic [RETIRE_W-1:0] retire_inc(input logic [RETIRE_W-1:0] v);
        return (v == '1) ? v : v + RETIRE_W'(1);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the sequencer and imem/dmem/control unit/datapath.
// master = sequencer side, slave = environment side.
interface instr_sequencer_if
    import cpu_seq_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
);

    logic                start;
    logic [INSTR_W-1:0]  instr_in;
    logic                imem_ready;
    logic                dmem_ready;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                branch_taken;
    logic                jmp_ctrl;
    logic [PC_W-1:0]     jmp_target;
    logic                done_ctrl;
    logic                reg_write;

    logic [PC_W-1:0]     pc;
    logic                imem_req;
    logic                ir_load;
    logic                decode_en;
    logic                dmem_req;
    logic                dmem_we;
    logic                reg_we;
    logic                busy;
    logic                halted;
    logic                fault;
    logic [RETIRE_W-1:0] instr_count;

    modport master (
        input  start, instr_in, imem_ready, dmem_ready,
        input  mem_read, mem_write, branch, branch_taken,
        input  jmp_ctrl, jmp_target, done_ctrl, reg_write,
        output pc, imem_req, ir_load, decode_en, dmem_req, dmem_we,
        output reg_we, busy, halted, fault, instr_count
    );

    modport slave (
        output start, instr_in, imem_ready, dmem_ready,
        output mem_read, mem_write, branch, branch_taken,
        output jmp_ctrl, jmp_target, done_ctrl, reg_write,
        input  pc, imem_req, ir_load, decode_en, dmem_req, dmem_we,
        input  reg_we, busy, halted, fault, instr_count
    );

endinterface

// File: rtl/instr_sequencer_mem_timeout.sv
// Wait-cycle counter for a memory handshake: cleared before the wait starts, counts
// enabled cycles, and flags expiry in the LIMIT-th enabled cycle.
module mem_timeout_counter #(
    parameter int unsigned LIMIT = 15,
    parameter int unsigned CNT_W = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // r_cnt holds the number of enabled cycles already elapsed, so the current one is r_cnt+1.
    assign o_expired = i_enable && (r_cnt >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns the PC, drives imem/dmem handshakes
// and turns decoded control strobes into one-cycle register-file / data-memory enables.
module instr_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned     PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     MEM_TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    instr_sequencer_if.master  bus
);

    seq_state_t          r_state;
    logic [PC_W-1:0]     r_pc;
    logic [RETIRE_W-1:0] r_count;
    logic                r_fault;
    logic [OFFS_W-1:0]   r_offs;

    logic                w_mem_clear;
    logic                w_mem_en;
    logic                w_expired;
    logic [PC_W-1:0]     w_offs_sext;
    logic [PC_W-1:0]     w_next_pc;

    assign w_mem_clear = (r_state == S_EXEC);
    assign w_mem_en    = (r_state == S_MEM);

    mem_timeout_counter #(
        .LIMIT (MEM_TIMEOUT),
        .CNT_W (TMO_W)
    ) u_mem_tmo (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_clear   (w_mem_clear),
        .i_enable  (w_mem_en),
        .o_expired (w_expired)
    );

    // Branch offset is captured at ir_load so imem may move on after the fetch.
    assign w_offs_sext = {{(PC_W - OFFS_W){r_offs[OFFS_W-1]}}, r_offs};

    always_comb begin
        w_next_pc = r_pc + PC_W'(1);
        if (bus.jmp_ctrl) begin
            w_next_pc = bus.jmp_target;
        end else if (bus.branch && bus.branch_taken) begin
            w_next_pc = r_pc + w_offs_sext;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_count <= '0;
            r_fault <= 1'b0;
            r_offs  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        r_state <= S_FETCH;
                        r_pc    <= RESET_PC;
                        r_count <= '0;
                        r_fault <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        r_offs  <= bus.instr_in[OFFS_MSB:OFFS_LSB];
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (bus.done_ctrl) begin
                        r_state <= S_HALT;
                    end else if (bus.mem_read || bus.mem_write) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    // A ready arriving in the expiry cycle still completes the access.
                    if (bus.dmem_ready) begin
                        r_state <= S_WB;
                    end else if (w_expired) begin
                        r_state <= S_HALT;
                        r_fault <= 1'b1;
                    end
                end
                S_WB: begin
                    r_pc    <= w_next_pc;
                    r_count <= retire_inc(r_count);
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.ir_load     = (r_state == S_FETCH) && bus.imem_ready;
    assign bus.decode_en   = (r_state == S_DECODE);
    assign bus.dmem_req    = (r_state == S_MEM);
    assign bus.dmem_we     = (r_state == S_MEM) && bus.mem_write;
    assign bus.reg_we      = (r_state == S_WB) && bus.reg_write;
    assign bus.busy        = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                             (r_state == S_EXEC)  || (r_state == S_MEM)    ||
                             (r_state == S_WB);
    assign bus.halted      = (r_state == S_HALT);
    assign bus.fault       = r_fault;
    assign bus.instr_count = r_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios followed by random
// instruction streams, checked cycle by cycle against an instruction-level model.
module tb_instr_sequencer;
    import cpu_seq_pkg::*;

    localparam int PCW    = 8;
    localparam int PC_MOD = 1 << PCW;
    localparam int TMO    = 15;

    // Instruction kinds used by the stimulus.
    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_HALT  = 3;
    localparam int K_RST   = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    instr_sequencer_if #(.PC_W(PCW)) sif();

    instr_sequencer #(
        .PC_W        (PCW),
        .RESET_PC    (8'h00),
        .MEM_TIMEOUT (TMO)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (sif.master)
    );

    int n_total = 0;
    int n_bad   = 0;

    int m_pc;
    int m_count;
    bit m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_next_pc(input int pc, input logic [8:0] ins, input bit br,
                                         input bit tk, input bit jp, input int tgt);
        int off;
        off = int'(ins[4:0]);
        if (off >= 16) off -= 32;
        if (jp) return tgt;
        if (br && tk) return (pc + off + PC_MOD) % PC_MOD;
        return (pc + 1) % PC_MOD;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctrl();
        sif.mem_read     = 1'b0;
        sif.mem_write    = 1'b0;
        sif.done_ctrl    = 1'b0;
        sif.reg_write    = 1'b0;
        sif.branch       = 1'b0;
        sif.branch_taken = 1'b0;
        sif.jmp_ctrl     = 1'b0;
        sif.jmp_target   = '0;
        sif.imem_ready   = 1'b0;
        sif.dmem_ready   = 1'b0;
        sif.start        = 1'b0;
    endtask

    // Caller is in an IDLE or HALT cycle; returns in the first FETCH cycle.
    task automatic do_start();
        sif.start = 1'b1;
        #1;
        check("pre_start_busy", sif.busy, 1'b0);
        tick();
        sif.start = 1'b0;
        m_pc    = 0;
        m_count = 0;
        m_fault = 1'b0;
    endtask

    // Caller is in the first FETCH cycle. Returns in the next FETCH cycle, or with
    // stopped=1 in the HALT cycle (done/timeout) or just after reset was asserted.
    task automatic do_instr(input int fdly, input logic [8:0] ins, input int kind,
                            input bit rw, input bit br, input bit tk, input bit jp,
                            input logic [7:0] tgt, input int ddly, output bit stopped);
        bit is_mem;
        is_mem  = (kind == K_LOAD) || (kind == K_STORE) || (kind == K_RST);
        stopped = 1'b0;
        for (int c = 0; c <= fdly; c++) begin
            sif.imem_ready = (c == fdly);
            sif.instr_in   = (c == fdly) ? ins : 9'($urandom);
            sif.start      = 1'($urandom);
            #1;
            check("fetch_req", sif.imem_req, 1'b1);
            check("fetch_pc", sif.pc, m_pc);
            check("ir_load", sif.ir_load, (c == fdly));
            check("count", sif.instr_count, m_count);
            check("fault", sif.fault, m_fault);
            tick();
        end
        sif.imem_ready   = 1'b0;
        sif.instr_in     = 9'($urandom);
        sif.start        = 1'($urandom);
        sif.mem_read     = (kind == K_LOAD) || (kind == K_RST);
        sif.mem_write    = (kind == K_STORE);
        sif.done_ctrl    = (kind == K_HALT);
        sif.reg_write    = rw;
        sif.branch       = br;
        sif.branch_taken = tk;
        sif.jmp_ctrl     = jp;
        sif.jmp_target   = tgt;
        #1;
        check("decode_en", sif.decode_en, 1'b1);
        check("dec_ir_load", sif.ir_load, 1'b0);
        tick();
        sif.start = 1'($urandom);
        #1;
        check("exec_busy", sif.busy, 1'b1);
        check("exec_decode_en", sif.decode_en, 1'b0);
        check("exec_reg_we", sif.reg_we, 1'b0);
        check("exec_dmem_req", sif.dmem_req, 1'b0);
        tick();
        sif.start = 1'b0;
        if (kind == K_HALT) begin
            #1;
            check("halt_halted", sif.halted, 1'b1);
            check("halt_busy", sif.busy, 1'b0);
            check("halt_pc", sif.pc, m_pc);
            check("halt_count", sif.instr_count, m_count);
            stopped = 1'b1;
            return;
        end
        if (is_mem) begin
            for (int c = 0; c < TMO; c++) begin
                if (kind == K_RST && c == ddly) begin
                    sif.dmem_ready = 1'b0;
                    #1;
                    check("rst_pre_dmem_req", sif.dmem_req, 1'b1);
                    reset_n = 1'b0;
                    #1;
                    check("rst_dmem_req", sif.dmem_req, 1'b0);
                    check("rst_dmem_we", sif.dmem_we, 1'b0);
                    check("rst_reg_we", sif.reg_we, 1'b0);
                    check("rst_pc", sif.pc, 8'h00);
                    check("rst_busy", sif.busy, 1'b0);
                    check("rst_halted", sif.halted, 1'b0);
                    check("rst_count", sif.instr_count, 16'h0000);
                    m_pc    = 0;
                    m_count = 0;
                    m_fault = 1'b0;
                    stopped = 1'b1;
                    return;
                end
                sif.dmem_ready = (kind != K_RST) && (c == ddly);
                #1;
                check("mem_dmem_req", sif.dmem_req, 1'b1);
                check("mem_dmem_we", sif.dmem_we, (kind == K_STORE));
                check("mem_reg_we", sif.reg_we, 1'b0);
                check("mem_pc", sif.pc, m_pc);
                if (c == ddly) break;
                tick();
            end
            if (ddly >= TMO) begin
                sif.dmem_ready = 1'b0;
                #1;
                check("tmo_halted", sif.halted, 1'b1);
                check("tmo_fault", sif.fault, 1'b1);
                check("tmo_reg_we", sif.reg_we, 1'b0);
                check("tmo_dmem_req", sif.dmem_req, 1'b0);
                check("tmo_pc", sif.pc, m_pc);
                check("tmo_count", sif.instr_count, m_count);
                m_fault = 1'b1;
                stopped = 1'b1;
                return;
            end
            tick();
            sif.dmem_ready = 1'b0;
        end
        #1;
        check("wb_reg_we", sif.reg_we, rw);
        check("wb_dmem_req", sif.dmem_req, 1'b0);
        check("wb_pc", sif.pc, m_pc);
        m_pc = model_next_pc(m_pc, ins, br, tk, jp, int'(tgt));
        if (m_count < 65535) m_count++;
        tick();
        clear_ctrl();
    endtask

    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            #1;
            check("hold_halted", sif.halted, 1'b1);
            check("hold_pc", sif.pc, m_pc);
            check("hold_count", sif.instr_count, m_count);
            check("hold_fault", sif.fault, m_fault);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit st;
        int r;
        int kind;
        int ddly;
        clear_ctrl();
        sif.instr_in = '0;
        m_pc = 0; m_count = 0; m_fault = 1'b0;

        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_pc", sif.pc, 8'h00);
        check("reset_busy", sif.busy, 1'b0);
        check("reset_halted", sif.halted, 1'b0);
        check("reset_fault", sif.fault, 1'b0);
        check("reset_count", sif.instr_count, 16'h0000);
        check("reset_imem_req", sif.imem_req, 1'b0);
        reset_n = 1'b1;
        tick();
        check("idle_busy", sif.busy, 1'b0);
        do_start();

        repeat (3) do_instr(0, 9'($urandom), K_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, st);
        check("straight_pc", sif.pc, 8'h03);
        check("straight_count", sif.instr_count, 16'd3);

        repeat (2) do_instr(0, 9'($urandom), K_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, st);
        do_instr(0, 9'b0000_11110, K_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, st);
        check("branch_taken_pc", sif.pc, 8'h03);
        do_instr(0, 9'($urandom), K_ALU, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 0, st);
        do_instr(0, 9'b0000_11110, K_ALU, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, st);
        check("branch_not_taken_pc", sif.pc, 8'h06);

        do_instr(1, 9'($urandom), K_ALU, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 0, st);
        do_instr(0, 9'($urandom), K_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, st);
        check("wrap_pc", sif.pc, 8'h00);
        do_instr(0, 9'b0000_00011, K_ALU, 1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 0, st);
        check("jmp_priority_pc", sif.pc, 8'h40);

        do_instr(0, 9'($urandom), K_ALU, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 0, st);
        do_instr(0, 9'($urandom), K_HALT, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, st);
        hold_halt(3);
        check("halt_pc_frozen", sif.pc, 8'h07);
        do_start();
        check("restart_pc", sif.pc, 8'h00);
        check("restart_count", sif.instr_count, 16'h0000);
        check("restart_busy", sif.busy, 1'b1);

        do_instr(0, 9'($urandom), K_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2, st);
        do_instr(0, 9'($urandom), K_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 99, st);
        hold_halt(2);
        check("timeout_fault_sticky", sif.fault, 1'b1);
        do_start();
        check("restart_fault_clear", sif.fault, 1'b0);
        do_instr(2, 9'($urandom), K_STORE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, TMO - 1, st);
        check("late_ready_halted", sif.halted, 1'b0);

        repeat (2) do_instr(0, 9'($urandom), K_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, st);
        do_instr(0, 9'($urandom), K_RST, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1, st);
        clear_ctrl();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_idle", sif.busy, 1'b0);
        do_start();

        for (int i = 0; i < 300; i++) begin
            r    = $urandom_range(0, 99);
            ddly = $urandom_range(0, TMO - 1);
            if (r < 50)      kind = K_ALU;
            else if (r < 70) kind = K_LOAD;
            else if (r < 85) kind = K_STORE;
            else if (r < 93) kind = K_HALT;
            else begin
                kind = K_LOAD;
                ddly = 99;
            end
            do_instr($urandom_range(0, 3), 9'($urandom), kind, 1'($urandom), 1'($urandom),
                     1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom), ddly, st);
            if (st) begin
                hold_halt($urandom_range(0, 2));
                do_start();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
